// File: rtl/riscv_core_pkg.sv
// +-----------------------------------------------------------------------------+
// | riscv_core_pkg : shared core constants, fetch response record, window test  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package riscv_core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic            err;
    } fetch_rsp_t;

    // Offset is (addr - base); wrap-around makes addresses below base look huge.
    function automatic logic off_in_window(input logic [XLEN-1:0] off,
                                           input logic [XLEN:0]   span_bytes);
        return ({1'b0, off} < span_bytes);
    endfunction

endpackage

`default_nettype wire

// File: rtl/resp_fifo2.sv
// +-----------------------------------------------------------------------------+
// | resp_fifo2 : two-entry in-order fetch response buffer with flush            |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module resp_fifo2
    import riscv_core_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       push_i,
    input  fetch_rsp_t push_data_i,
    input  logic       pop_i,
    output fetch_rsp_t head_o,
    output logic [1:0] count_o
);

    fetch_rsp_t entry_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push;
    logic       do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the top gates the head with the valid flag.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            entry_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = entry_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/instr_mem_responder.sv
// +-----------------------------------------------------------------------------+
// | instr_mem_responder : synchronous instruction memory with valid/ready fetch |
// | port and 2-deep response buffer. Optional macro INSTR_MEM_MISALIGN_CHECK_EN |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module instr_mem_responder
    import riscv_core_pkg::*;
#(
    parameter int unsigned     DEPTH_WORDS = 256,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_instr,
    output logic            rsp_err,
    input  logic            flush,
    input  logic            prog_we,
    input  logic [XLEN-1:0] prog_addr,
    input  logic [XLEN-1:0] prog_data
);

    localparam int unsigned     IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [XLEN:0]   SPAN_BYTES = (XLEN+1)'(DEPTH_WORDS) << 2;

    logic [XLEN-1:0]  mem_q [DEPTH_WORDS];
    logic [XLEN-1:0]  rd_data_q;
    logic             inflight_q, inflight_d;
    logic             rd_err_q, rd_err_d;

    logic [XLEN-1:0]  req_off;
    logic [XLEN-1:0]  prog_off;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] prog_idx;
    logic             req_fault;
    logic             prog_ok;
    logic             accept;
    logic             rd_en;

    fetch_rsp_t       bypass_rsp;
    fetch_rsp_t       fifo_head;
    fetch_rsp_t       out_rsp;
    logic [1:0]       fifo_count;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [1:0]       occupancy;

    always_comb begin
        req_off  = req_addr - BASE_ADDR;
        prog_off = prog_addr - BASE_ADDR;
        req_idx  = req_off[IDX_W+1:2];
        prog_idx = prog_off[IDX_W+1:2];
        prog_ok  = off_in_window(prog_off, SPAN_BYTES);
`ifdef INSTR_MEM_MISALIGN_CHECK_EN
        req_fault = !off_in_window(req_off, SPAN_BYTES) || (req_addr[1:0] != 2'b00);
`else
        req_fault = !off_in_window(req_off, SPAN_BYTES);
`endif
    end

    // Ready depends only on state, reset and flush, never on req_valid.
    always_comb begin
        fifo_empty = (fifo_count == 2'd0);
        occupancy  = {1'b0, inflight_q} + fifo_count;
        req_ready  = rst && !flush && (occupancy < 2'd2);
        accept     = req_valid && req_ready;
        rd_en      = accept && !req_fault;
        inflight_d = accept && !flush;
        rd_err_d   = accept ? req_fault : rd_err_q;
    end

    // Non-blocking read and write in one block gives read-before-write.
    always_ff @(posedge clk) begin
        if (prog_we && prog_ok) begin
            mem_q[prog_idx] <= prog_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[req_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            rd_err_q   <= rd_err_d;
        end
    end

    // The read register is presented directly when the buffer is empty,
    // which gives single-cycle latency and full throughput.
    always_comb begin
        bypass_rsp.instr = rd_err_q ? INSTR_NOP : rd_data_q;
        bypass_rsp.err   = rd_err_q;
        out_rsp          = fifo_empty ? bypass_rsp : fifo_head;
        rsp_valid        = inflight_q || !fifo_empty;
        fifo_pop         = rsp_valid && rsp_ready && !fifo_empty;
        fifo_push        = inflight_q && !(fifo_empty && rsp_ready);
        rsp_instr        = rsp_valid ? out_rsp.instr : '0;
        rsp_err          = rsp_valid ? out_rsp.err : 1'b0;
    end

    resp_fifo2 u_resp_fifo2 (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (fifo_push),
        .push_data_i (bypass_rsp),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
// +-----------------------------------------------------------------------------+
// | tb_instr_mem_responder : table vectors plus queue scoreboard for fetches    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_instr_mem_responder;
    import riscv_core_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          NV    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        flush;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;

    always #5 clk = ~clk;

    instr_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    exp_t cur_exp;
    vec_t vt [NV];
    logic [31:0] pa [6];
    logic [31:0] pd [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic [31:0] addr, input logic [31:0] instr, input logic err);
        req_valid     = 1'b1;
        req_addr      = addr;
        cur_exp.instr = instr;
        cur_exp.err   = err;
    endtask

    // Scoreboard update just before the active edge, then advance one cycle.
    task automatic cycle();
        exp_t e;
        #2;
        if (rst) begin
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %h/%0b expected no response", rsp_instr, rsp_err);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_instr", rsp_instr, e.instr);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                end
            end
            if (flush) sb_q.delete();
            if (req_valid && req_ready) sb_q.push_back(cur_exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; cur_exp = '0;

        pa[0] = 32'h0;   pd[0] = 32'h11;
        pa[1] = 32'h400; pd[1] = 32'hDEAD_BEEF;   // out of range, must not alias word 0
        pa[2] = 32'h4;   pd[2] = 32'h22;
        pa[3] = 32'h8;   pd[3] = 32'h33;
        pa[4] = 32'hC;   pd[4] = 32'h44;
        pa[5] = 32'h3FC; pd[5] = 32'h55;

        vt[0] = '{32'h0,        32'h11,    1'b0};
        vt[1] = '{32'h4,        32'h22,    1'b0};
        vt[2] = '{32'h8,        32'h33,    1'b0};
        vt[3] = '{32'hC,        32'h44,    1'b0};
        vt[4] = '{32'h3FC,      32'h55,    1'b0};
        vt[5] = '{32'h400,      INSTR_NOP, 1'b1};
        vt[6] = '{32'hFFFF_FFFC, INSTR_NOP, 1'b1};
`ifdef INSTR_MEM_MISALIGN_CHECK_EN
        vt[7] = '{32'h2,        INSTR_NOP, 1'b1};
`else
        vt[7] = '{32'h2,        32'h11,    1'b0};
`endif

        #1;
        check("reset_req_ready", {31'b0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_instr", rsp_instr, 32'd0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("req_ready_after_reset", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            prog_we = 1'b1; prog_addr = pa[i]; prog_data = pd[i];
            cycle();
        end
        prog_we = 1'b0;

        rsp_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            set_req(vt[i].addr, vt[i].instr, vt[i].err);
            #1;
            check("req_ready_stream", {31'b0, req_ready}, 32'd1);
            if (i > 0) check("rsp_valid_stream", {31'b0, rsp_valid}, 32'd1);
            cycle();
        end
        req_valid = 1'b0;
        #1;
        check("rsp_valid_last", {31'b0, rsp_valid}, 32'd1);
        cycle();
        check("rsp_valid_idle", {31'b0, rsp_valid}, 32'd0);

        rsp_ready = 1'b0;
        set_req(32'h0, 32'h11, 1'b0);
        #1; check("bp_ready0", {31'b0, req_ready}, 32'd1);
        cycle();
        set_req(32'h4, 32'h22, 1'b0);
        #1; check("bp_ready1", {31'b0, req_ready}, 32'd1);
        check("bp_head1", rsp_instr, 32'h11);
        cycle();
        set_req(32'h8, 32'h33, 1'b0);
        #1; check("bp_full_ready", {31'b0, req_ready}, 32'd0);
        cycle();
        check("bp_full_ready2", {31'b0, req_ready}, 32'd0);
        check("bp_hold_instr", rsp_instr, 32'h11);
        check("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        #1; check("bp_drain_ready", {31'b0, req_ready}, 32'd0);
        cycle();
        check("bp_third_ready", {31'b0, req_ready}, 32'd1);
        check("bp_second_head", rsp_instr, 32'h22);
        cycle();
        req_valid = 1'b0;
        cycle();
        check("bp_idle", {31'b0, rsp_valid}, 32'd0);

        rsp_ready = 1'b0;
        set_req(32'h0, 32'h11, 1'b0); cycle();
        set_req(32'h4, 32'h22, 1'b0); cycle();
        req_valid = 1'b0; cycle();
        check("fl_buffered", {31'b0, rsp_valid}, 32'd1);
        flush = 1'b1;
        set_req(32'hC, 32'h44, 1'b0);
        #1; check("fl_req_ready", {31'b0, req_ready}, 32'd0);
        cycle();
        flush = 1'b0; req_valid = 1'b0;
        #1; check("fl_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rsp_ready = 1'b1;
        set_req(32'h8, 32'h33, 1'b0); cycle();
        req_valid = 1'b0; cycle();
        check("fl_idle", {31'b0, rsp_valid}, 32'd0);

        set_req(32'h4, 32'h22, 1'b0);
        prog_we = 1'b1; prog_addr = 32'h4; prog_data = 32'h99;
        cycle();
        prog_we = 1'b0;
        set_req(32'h4, 32'h99, 1'b0); cycle();
        req_valid = 1'b0; cycle();

        rsp_ready = 1'b0;
        set_req(32'h0, 32'h11, 1'b0); cycle();
        set_req(32'h8, 32'h33, 1'b0); cycle();
        req_valid = 1'b0;
        #1; check("rs_pending", {31'b0, rsp_valid}, 32'd1);
        rst = 1'b0;
        #1;
        check("rs_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rs_req_ready", {31'b0, req_ready}, 32'd0);
        check("rs_rsp_instr", rsp_instr, 32'd0);
        sb_q.delete();
        repeat (2) cycle();
        rst = 1'b1;
        #1; check("rs_ready_after", {31'b0, req_ready}, 32'd1);
        rsp_ready = 1'b1;
        set_req(32'h0, 32'h11, 1'b0); cycle();
        req_valid = 1'b0; cycle();
        check("rs_idle", {31'b0, rsp_valid}, 32'd0);

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: instruction words stored, power of two.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1: fetch request present.
REQ-006 SHALL have port req_ready, output, 1: request accepted when req_valid and req_ready are both high.
REQ-007 SHALL have port req_addr, input, 32: byte address of the fetch (the current PC).
REQ-008 SHALL have port rsp_valid, output, 1: response present.
REQ-009 SHALL have port rsp_ready, input, 1: consumer takes the response.
REQ-010 SHALL have port rsp_instr, output, 32: fetched instruction word.
REQ-011 SHALL have port rsp_err, output, 1: fetch fault (out of range or misaligned).
REQ-012 SHALL have port flush, input, 1: discard all in-flight and buffered responses (redirect).
REQ-013 SHALL have port prog_we, input, 1: program-load write strobe.
REQ-014 SHALL have port prog_addr, input, 32: byte address of the write.
REQ-015 SHALL have port prog_data, input, 32: word written.

Function
REQ-016 SHALL read memory synchronously: an accepted request's data enters the response path 1 cycle after acceptance, so minimum request-to-rsp_valid latency is 1 cycle.
REQ-017 SHALL buffer responses in a 2-entry in-order FIFO; req_ready is high iff (in-flight read + FIFO occupancy) < 2, independent of req_valid (no combinational path req_valid->req_ready).
REQ-018 SHALL sustain one request accepted and one response delivered per cycle when rsp_ready is held high.
REQ-019 SHALL hold rsp_instr and rsp_err stable while rsp_valid is high and rsp_ready is low.
REQ-020 SHALL deliver responses in request order; a response leaves the FIFO on the cycle rsp_valid and rsp_ready are both high.
REQ-021 SHALL treat an address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) as a fault: rsp_instr = NOP (32'h0000_0013), rsp_err = 1.
REQ-022 SHALL index memory with (req_addr - BASE_ADDR) >> 2; bits [1:0] are ignored for indexing.
REQ-023 SHALL, on prog_we for an in-range prog_addr, write prog_data at the next edge; an out-of-range write is dropped silently.
REQ-024 SHALL return the old word when a read and a prog_we to the same word occur on the same cycle (read-before-write).
REQ-025 SHALL, when flush is high, empty the FIFO and cancel the in-flight read at that edge; rsp_valid is low the next cycle; a request presented on the flush cycle is not accepted (req_ready forced low that cycle).
REQ-026 SHALL keep rsp_valid low when no response is buffered; FIFO full and in-flight both occupied implies req_ready low.

Reset
REQ-027 SHALL, while rst is low, force req_ready=0, rsp_valid=0, rsp_instr=0, rsp_err=0, FIFO pointers/count=0, in-flight flag=0; memory contents are not reset.
REQ-028 SHALL assert req_ready on the first cycle after rst deasserts; reset mid-transaction discards all pending responses.

Configuration
REQ-029 SHALL, with macro INSTR_MEM_MISALIGN_CHECK_EN defined, flag req_addr[1:0] != 0 as a fault (rsp_instr = NOP, rsp_err = 1, memory not read).
REQ-030 SHALL, without INSTR_MEM_MISALIGN_CHECK_EN, ignore req_addr[1:0] entirely and raise rsp_err only for out-of-range.

Structure
REQ-031 SHALL take XLEN (32), INSTR_NOP (32'h0000_0013) and the response record (instr, err) from shared package riscv_core_pkg.
REQ-032 SHALL implement the 2-entry response buffer as sub-module resp_fifo2.

Verification
REQ-033 SHALL test: program words 0..3 = 0x11,0x22,0x33,0x44; requests to 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1 -> responses 0x11,0x22,0x33,0x44 on consecutive cycles, err=0.
REQ-034 SHALL test: rsp_ready=0 and 3 requests offered -> exactly 2 accepted, req_ready low; rsp_ready=1 -> both drained in order, then third accepted.
REQ-035 SHALL test: request to BASE_ADDR+4*DEPTH_WORDS -> rsp_instr=0x00000013, rsp_err=1.
REQ-036 SHALL test: request 0x2 -> err=1 and NOP with INSTR_MEM_MISALIGN_CHECK_EN; word 0 and err=0 without.
REQ-037 SHALL test: 2 responses buffered, flush pulsed -> rsp_valid=0 next cycle; next request to 0x8 returns 0x33.
REQ-038 SHALL test: rst driven low with 2 responses pending -> rsp_valid=0 immediately; after release req_ready=1 and memory still holds 0x11 at 0x0.
